// File: rtl/comm_bus_arb_if.sv
// rtl/comm_bus_arb_if.sv - requester handshake and nibble pin bundle for comm_bus_arb
interface comm_bus_arb_if;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic [3:0]  data_op_en;
  logic        data_en;

  modport slave (
    input  req, wr, wdata, data_in, data_en,
    output gnt, done, rdata, err, busy, data_out, data_op_en
  );

  modport master (
    output req, wr, wdata, data_in, data_en,
    input  gnt, done, rdata, err, busy, data_out, data_op_en
  );
endinterface

// File: rtl/comm_bus_arb.sv
// rtl/comm_bus_arb.sv - round-robin arbiter moving one byte as two nibbles over the shared pin port
// Optional strobe timeout abort enabled by defining COMM_ARB_TIMEOUT_EN.
module comm_bus_arb #(
  parameter int TO_W = 10
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  comm_bus_arb_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_idx;
  logic       r_wr;
  logic [7:0] r_byte;
  logic [7:0] r_rdata;
  logic [3:0] r_hi_nib;
  logic       r_err;
  logic [1:0] r_sync;
  logic       r_sync_d;

  logic       w_strb;
  logic       w_timeout;
  logic [1:0] w_sel;
  logic [1:0] w_ptr_nxt;
  logic [2:0] w_onehot;

  assign w_strb   = r_sync[1] & ~r_sync_d;
  assign w_onehot = 3'b001 << r_idx;

  // First requesting index at or after r_ptr, cyclic 0->1->2->0.
  always_comb begin
    w_sel = 2'd0;
    case (r_ptr)
      2'd1:    w_sel = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    w_sel = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: w_sel = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_ptr_nxt = 2'd0;
    case (w_sel)
      2'd0:    w_ptr_nxt = 2'd1;
      2'd1:    w_ptr_nxt = 2'd2;
      default: w_ptr_nxt = 2'd0;
    endcase
  end

`ifdef COMM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;

  // Held at zero outside HI/LO, so entry to either state starts from zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (((r_state != S_HI) && (r_state != S_LO)) || w_strb) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = ((r_state == S_HI) || (r_state == S_LO)) && !w_strb &&
                     (r_cnt == {{(TO_W-1){1'b1}}, 1'b0});
`else
  logic [TO_W-1:0] w_unused_to;
  assign w_unused_to = '0;
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_idx    <= 2'd0;
      r_wr     <= 1'b0;
      r_byte   <= 8'h00;
      r_rdata  <= 8'h00;
      r_hi_nib <= 4'h0;
      r_err    <= 1'b0;
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], bus.data_en};
      r_sync_d <= r_sync[1];
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_idx   <= w_sel;
            r_wr    <= bus.wr[w_sel];
            r_byte  <= bus.wdata[{w_sel, 3'b000} +: 8];
            r_ptr   <= w_ptr_nxt;
            r_err   <= 1'b0;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_strb) begin
            if (!r_wr) r_hi_nib <= bus.data_in;
            r_state <= S_LO;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_LO: begin
          // High nibble is parked until the byte completes so an abort leaves rdata intact.
          if (w_strb) begin
            if (!r_wr) r_rdata <= {r_hi_nib, bus.data_in};
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.gnt        = 3'b000;
    bus.done       = 3'b000;
    bus.err        = 1'b0;
    bus.data_out   = 4'h0;
    bus.data_op_en = 4'h0;
    case (r_state)
      S_HI: begin
        bus.gnt        = w_onehot;
        bus.data_op_en = r_wr ? 4'hF : 4'h0;
        bus.data_out   = r_wr ? r_byte[7:4] : 4'h0;
      end
      S_LO: begin
        bus.gnt        = w_onehot;
        bus.data_op_en = r_wr ? 4'hF : 4'h0;
        bus.data_out   = r_wr ? r_byte[3:0] : 4'h0;
      end
      S_DONE: begin
        bus.done = w_onehot;
        bus.err  = r_err;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.rdata = r_rdata;

endmodule

// File: doc/comm_bus_arb.md
# comm_bus_arb

Round-robin arbiter and sequencer for the shared 4-bit external data port of the communication IC. Three internal requesters (UART, SPI and I2C engines) contend for the nibble port. The block grants one requester at a time and moves one byte as two nibbles, high nibble first, paced by the host strobe `data_en`. It owns `data_out`/`data_op_en` and is the only driver of that port.

## Interface
- `TO_W`, 10, timeout counter width; a transfer aborts after 2^TO_W−1 cycles without a strobe.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 3: request per requester; index 0 = UART, 1 = SPI, 2 = I2C. Held high until `done`.
- `wr` in 3: per-requester direction, sampled at grant; 1 = byte out to the pins, 0 = byte in from the pins.
- `wdata` in 24: per-requester write byte; requester i uses [8i+7:8i]; sampled at grant.
- `gnt` out 3: one-hot grant, high for the whole transfer.
- `done` out 3: one-cycle completion pulse to the granted requester.
- `rdata` out 8: captured byte; valid in the cycle `done` is high for a read.
- `err` out 1: one-cycle pulse, coincident with `done`, on timeout abort.
- `busy` out 1: high in any state other than IDLE.
- `data_in` in 4: nibble from the pins.
- `data_out` out 4: nibble to the pins.
- `data_op_en` out 4: pin output enables; 4'hF when driving, 4'h0 otherwise.
- `data_en` in 1: asynchronous host strobe.

## Operation
- `data_en` passes through a 2-flop synchronizer. `strb` is the rising edge of the synchronized signal: a one-cycle pulse.
- FSM states: IDLE, HI, LO, DONE.
- IDLE:
  - If any `req` bit is high, select the first requester at or after `ptr` in cyclic order 0→1→2→0.
  - Latch its index, `wr` bit and byte.
  - Set `gnt`, set `ptr` = index+1 mod 3, go to HI.
- HI:
  - Write: `data_out`=byte[7:4], `data_op_en`=4'hF.
  - Read: `data_out`=0, `data_op_en`=0.
  - On `strb`: for a read, capture `data_in` into `rdata[7:4]`. Go to LO.
- LO: same as HI using byte[3:0] / `rdata[3:0]`. On `strb` go to DONE.
- DONE:
  - `done[idx]`=1 and `gnt` cleared, `data_op_en`=0, for one cycle.
  - Go to IDLE.
- `strb` in IDLE or DONE is ignored.
- Dropping `req` during a transfer is ignored; the transfer completes.
- A requester whose `req` is still high in the cycle after `done` is re-eligible, but it has lowest priority because of `ptr`.
- `rdata` holds its value until the next read capture. Write transfers leave `rdata` unchanged.
- Reset values: `ptr`=0, state IDLE, and all outputs (`gnt`, `done`, `rdata`, `err`, `busy`, `data_out`, `data_op_en`) 0; synchronizer flops 0.
- Reset mid-transfer: outputs clear immediately (asynchronous). No `done` is issued; requesters restart after reset.

## Timing
- `req` seen in IDLE at cycle n → `gnt` and the driven nibble are visible at n+1.
- A pin rising edge on `data_en` → `strb` 2–3 cycles later.
- Host holds `data_in` stable from before `data_en` rises until `data_en` falls. Host keeps `data_en` low for at least 3 cycles between strobes.
- Second `strb` at cycle m → `done`/`rdata` at m+1.
- Back-to-back: `done` at d → next `gnt` at d+2 at the earliest.
- `busy` is high from the grant cycle through DONE inclusive.

## Configuration
- `COMM_ARB_TIMEOUT_EN` defined:
  - A TO_W-bit counter clears on entry to HI/LO and on each `strb`, and increments otherwise.
  - On reaching all-ones, go to DONE with `err`=1. `rdata` is not updated by that transfer.
- Not defined: no counter; the block waits indefinitely for `strb`; `err` is tied 0.

## Test plan
- Write from SPI: `req`=3'b010, `wr[1]`=1, byte 0xA5 → `gnt`=3'b010 next cycle, `data_out`=4'hA with `data_op_en`=4'hF; after the first strobe `data_out`=4'h5; after the second strobe `done`=3'b010, `err`=0.
- Read for UART: `wr[0]`=0, host presents 4'h3 then 4'hC on strobes → `data_op_en`=0 throughout; `rdata`=0x3C with `done[0]`.
- Fairness: `req`=3'b111 held continuously → grant order 0,1,2,0; no requester is granted twice before the others are served.
- Timeout (macro on, TO_W=4): grant with no strobe → `err` and `done` pulse 15 cycles after entering HI; `rdata` unchanged. With the macro off, the same stimulus leaves `busy` high indefinitely.
- Reset mid-transfer: assert `reset_n`=0 in LO → all outputs 0 asynchronously, no `done`; after release with `req`=3'b100, I2C is granted first.
